// File: rtl/upe_triplemul_seq_pkg.sv
// Shared types and helpers for the triple-multiplier sequencer.
package upe_triplemul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_t;

  localparam int NBITS_DEFAULT = 64;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << w) < 64'(value)) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/upe_triplemul_seq_bit_serializer.sv
// LSB-first serializer: holds each bit of data on led_bit for BIT_PERIOD cycles.
module upe_bit_serializer
  import upe_triplemul_seq_pkg::*;
#(
  parameter int BIT_PERIOD = 1250,
  parameter int NBITS      = NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [NBITS-1:0] data,
  input  logic             abort,
  output logic             led_bit,
  output logic             done
);

  localparam int PW = clog2_min1(BIT_PERIOD);
  localparam int IW = clog2_min1(NBITS);

  logic [PW-1:0] per_cnt_reg;
  logic [IW-1:0] bit_idx_reg;
  logic          active_reg;
  logic          period_end;
  logic          last_bit;
  logic [IW-1:0] bit_idx_next;

  assign period_end   = (per_cnt_reg == PW'(BIT_PERIOD - 1));
  assign last_bit     = (bit_idx_reg == IW'(NBITS - 1));
  assign bit_idx_next = bit_idx_reg + IW'(1);
  assign done         = active_reg && period_end && last_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_reg <= '0;
      bit_idx_reg <= '0;
      active_reg  <= 1'b0;
      led_bit     <= 1'b0;
    end else if (abort) begin
      per_cnt_reg <= '0;
      bit_idx_reg <= '0;
      active_reg  <= 1'b0;
      led_bit     <= 1'b0;
    end else if (load) begin
      per_cnt_reg <= '0;
      bit_idx_reg <= '0;
      active_reg  <= 1'b1;
      led_bit     <= data[0];
    end else if (active_reg) begin
      if (period_end) begin
        per_cnt_reg <= '0;
        if (last_bit) begin
          bit_idx_reg <= '0;
          active_reg  <= 1'b0;
          led_bit     <= 1'b0;
        end else begin
          bit_idx_reg <= bit_idx_next;
          led_bit     <= data[bit_idx_next];
        end
      end else begin
        per_cnt_reg <= per_cnt_reg + PW'(1);
      end
    end
  end

endmodule

// File: rtl/upe_triplemul_seq.sv
// Sequencer for the external 16-bit triple multiplier: registers operands, waits out
// the combinational settle time, captures the result and serializes it onto an LED.
module upe_triplemul_seq
  import upe_triplemul_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int BIT_PERIOD    = 1250,
  parameter int NBITS         = NBITS_DEFAULT,
  parameter int SERIAL_EN     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [15:0]      in_c,
  input  logic             in_sel,
  input  logic             abort,
  output logic [15:0]      mul_a,
  output logic [15:0]      mul_b,
  output logic [15:0]      mul_c,
  input  logic [NBITS-1:0] mul_out,
  input  logic [NBITS-1:0] mul_probe,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [NBITS-1:0] res_data,
  output logic             led_bit,
  output logic             busy
);

  localparam int SW = clog2_min1(SETTLE_CYCLES + 1);

  state_t          state_reg;
  logic [SW-1:0]   settle_cnt_reg;
  logic            sel_reg;
  logic            accept;
  logic            capture;
  logic            ser_load;
  logic            ser_done;
  logic [NBITS-1:0] cap_data;
  logic [NBITS-1:0] ser_data;

  assign in_ready = (state_reg == ST_IDLE) && !abort;
  assign accept   = in_valid && in_ready;
  assign capture  = (state_reg == ST_SETTLE) && (settle_cnt_reg == '0) && !abort;
  assign cap_data = sel_reg ? mul_probe : mul_out;
  assign ser_load = capture && (SERIAL_EN != 0);
  // On the capture edge res_data is not yet written, so feed the serializer the live value.
  assign ser_data = capture ? cap_data : res_data;

  upe_bit_serializer #(
    .BIT_PERIOD (BIT_PERIOD),
    .NBITS      (NBITS)
  ) u_serializer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ser_load),
    .data    (ser_data),
    .abort   (abort),
    .led_bit (led_bit),
    .done    (ser_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      settle_cnt_reg <= '0;
      sel_reg        <= 1'b0;
      mul_a          <= '0;
      mul_b          <= '0;
      mul_c          <= '0;
      res_data       <= '0;
      res_valid      <= 1'b0;
      busy           <= 1'b0;
    end else if (abort) begin
      state_reg      <= ST_IDLE;
      settle_cnt_reg <= '0;
      res_valid      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      // Consumer handshake is honoured in every state; a capture below overrides it.
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            mul_a          <= in_a;
            mul_b          <= in_b;
            mul_c          <= in_c;
            sel_reg        <= in_sel;
            settle_cnt_reg <= SW'(SETTLE_CYCLES - 1);
            state_reg      <= ST_SETTLE;
            busy           <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_reg == '0) begin
            res_data  <= cap_data;
            res_valid <= 1'b1;
            state_reg <= (SERIAL_EN != 0) ? ST_SHIFT : ST_WAIT_ACK;
          end else begin
            settle_cnt_reg <= settle_cnt_reg - SW'(1);
          end
        end
        ST_SHIFT: begin
          if (ser_done) begin
            state_reg <= res_valid ? ST_WAIT_ACK : ST_IDLE;
            busy      <= res_valid;
          end
        end
        ST_WAIT_ACK: begin
          if (!res_valid || res_ready) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upe_triplemul_seq.sv
// Self-checking bench for upe_triplemul_seq with a table-driven multiplier model
// and a result scoreboard.
module tb_upe_triplemul_seq;

  localparam int NB = 64;
  localparam int BP = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_a, in_b, in_c;
  logic          in_sel;
  logic          abort;
  logic [15:0]   mul_a, mul_b, mul_c;
  logic [NB-1:0] mul_out, mul_probe;
  logic          res_valid;
  logic          res_ready;
  logic [NB-1:0] res_data;
  logic          led_bit;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;
  logic [NB-1:0] exp_q[$];

  always #5 clk = ~clk;

  upe_triplemul_seq #(
    .SETTLE_CYCLES (SC),
    .BIT_PERIOD    (BP),
    .NBITS         (NB),
    .SERIAL_EN     (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_sel    (in_sel),
    .abort     (abort),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_c     (mul_c),
    .mul_out   (mul_out),
    .mul_probe (mul_probe),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .led_bit   (led_bit),
    .busy      (busy)
  );

  // Multiplier stand-in: results keyed on the operand triple.
  function automatic logic [NB-1:0] model_out(input logic [15:0] a, b, c);
    if (a == 16'h0003 && b == 16'h0003 && c == 16'h0003) return 64'h000000007F7DF7D7;
    return {a, b, c, 16'hC0DE};
  endfunction

  function automatic logic [NB-1:0] model_probe(input logic [15:0] a, b, c);
    if (a == 16'h0003 && b == 16'h0003 && c == 16'h0003) return 64'h5555555555555555;
    return ~{a, b, c, 16'hC0DE};
  endfunction

  always_comb begin
    mul_out   = model_out(mul_a, mul_b, mul_c);
    mul_probe = model_probe(mul_a, mul_b, mul_c);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare res_data on every completed result handshake.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && res_valid && res_ready) begin
      n_txn++;
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected", res_data, 64'h0);
      end else begin
        logic [NB-1:0] e;
        e = exp_q.pop_front();
        $display("txn %0d: res_data=%h expected=%h", n_txn, res_data, e);
        check_eq("sb_res_data", res_data, e);
      end
    end
  end

  task automatic discard_expected();
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic [15:0] a, b, c, input logic sel);
    int t;
    t = 0;
    while (!in_ready && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check_eq("send_timeout", 64'(in_ready), 64'd1);
    in_a = a; in_b = b; in_c = c; in_sel = sel; in_valid = 1'b1;
    exp_q.push_back(sel ? model_probe(a, b, c) : model_out(a, b, c));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!res_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!res_valid) check_eq("valid_timeout", 64'(res_valid), 64'd1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (busy) check_eq("idle_timeout", 64'(busy), 64'd0);
  endtask

  // Checks led_bit on every sample of the first nb bit periods.
  task automatic check_stream(input string tag, input logic [NB-1:0] exp, input int nb);
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < BP; j++) begin
        check_eq(tag, 64'(led_bit), 64'(exp[k]));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0;
    in_sel = 1'b0; abort = 1'b0; res_ready = 1'b1;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_res_valid", 64'(res_valid), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Reset asserted mid-SHIFT
    res_ready = 1'b0;
    send(16'h0003, 16'h0003, 16'h0003, 1'b0);
    wait_valid();
    repeat (6) @(negedge clk);
    check_eq("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_mul_a", 64'(mul_a), 64'd0);
    check_eq("async_rst_res_data", res_data, 64'd0);
    check_eq("async_rst_res_valid", 64'(res_valid), 64'd0);
    check_eq("async_rst_led", 64'(led_bit), 64'd0);
    check_eq("async_rst_busy", 64'(busy), 64'd0);
    check_eq("async_rst_in_ready", 64'(in_ready), 64'd1);
    discard_expected();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_in_ready", 64'(in_ready), 64'd1);
    check_eq("rel_busy", 64'(busy), 64'd0);

    // Latency and first bits of mul_out
    res_ready = 1'b1;
    send(16'h0003, 16'h0003, 16'h0003, 1'b0);
    check_eq("lat_busy", 64'(busy), 64'd1);
    check_eq("lat_mul_a", 64'(mul_a), 64'h3);
    check_eq("lat_valid_n0", 64'(res_valid), 64'd0);
    for (int i = 1; i < SC; i++) begin
      @(negedge clk);
      check_eq("lat_valid_early", 64'(res_valid), 64'd0);
    end
    @(negedge clk);
    check_eq("lat_valid_on_time", 64'(res_valid), 64'd1);
    check_eq("lat_res_data", res_data, 64'h000000007F7DF7D7);
    check_stream("led_out", 64'h000000007F7DF7D7, 8);
    wait_idle();
    check_eq("out_end_led", 64'(led_bit), 64'd0);

    // Probe capture, full serialization
    send(16'h0003, 16'h0003, 16'h0003, 1'b1);
    wait_valid();
    check_eq("probe_res_data", res_data, 64'h5555555555555555);
    check_stream("led_probe", 64'h5555555555555555, NB);
    check_eq("probe_end_led", 64'(led_bit), 64'd0);
    check_eq("probe_end_busy", 64'(busy), 64'd0);
    check_eq("probe_end_in_ready", 64'(in_ready), 64'd1);

    // Consumer stalls through SHIFT -> WAIT_ACK
    res_ready = 1'b0;
    send(16'h0003, 16'h0003, 16'h0003, 1'b0);
    wait_valid();
    repeat (BP * NB) @(negedge clk);
    check_eq("wack_busy", 64'(busy), 64'd1);
    check_eq("wack_in_ready", 64'(in_ready), 64'd0);
    check_eq("wack_res_valid", 64'(res_valid), 64'd1);
    check_eq("wack_led", 64'(led_bit), 64'd0);
    in_a = 16'h1111; in_b = 16'h2222; in_c = 16'h4444; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("wack_mul_a_hold", 64'(mul_a), 64'h3);
    res_ready = 1'b1;
    @(negedge clk);
    check_eq("ack_res_valid", 64'(res_valid), 64'd0);
    check_eq("ack_busy", 64'(busy), 64'd0);
    check_eq("ack_in_ready", 64'(in_ready), 64'd1);

    // Input ignored while busy, then accepted from IDLE
    send(16'h0003, 16'h0003, 16'h0003, 1'b0);
    in_a = 16'h3281; in_b = 16'h1E6D; in_c = 16'h1553; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check_eq("busy_ign_mul_a", 64'(mul_a), 64'h3);
    check_eq("busy_ign_mul_c", 64'(mul_c), 64'h3);
    wait_idle();
    send(16'h3281, 16'h1E6D, 16'h1553, 1'b0);
    check_eq("acc_mul_a", 64'(mul_a), 64'h3281);
    check_eq("acc_mul_b", 64'(mul_b), 64'h1E6D);
    check_eq("acc_mul_c", 64'(mul_c), 64'h1553);
    repeat (SC - 1) @(negedge clk);
    check_eq("acc_valid_early", 64'(res_valid), 64'd0);
    @(negedge clk);
    check_eq("acc_valid", 64'(res_valid), 64'd1);
    check_eq("acc_led0", 64'(led_bit), 64'(res_data[0]));
    wait_idle();

    // Abort in SETTLE, then abort racing an accept
    send(16'h0102, 16'h0304, 16'h0506, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_res_valid", 64'(res_valid), 64'd0);
    check_eq("abort_in_ready", 64'(in_ready), 64'd0);
    check_eq("abort_mul_a_keep", 64'(mul_a), 64'h0102);
    discard_expected();
    in_a = 16'hBEEF; in_b = 16'hCAFE; in_c = 16'hF00D; in_valid = 1'b1;
    @(negedge clk);
    check_eq("abort_acc_mul_a", 64'(mul_a), 64'h0102);
    check_eq("abort_acc_busy", 64'(busy), 64'd0);
    abort = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < SC + 2; i++) begin
      @(negedge clk);
      check_eq("abort_no_capture", 64'(res_valid), 64'd0);
    end
    check_eq("abort_res_data_keep", res_data, model_out(16'h3281, 16'h1E6D, 16'h1553));

    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
